// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and default-slave state type
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // NONSEQ and SEQ are the only transfer types that carry a real data phase
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_decode_mux_dp_if.sv
// rtl/ahb_decode_mux_dp_if.sv - master-side and slave-array signal bundle for the AHB interconnect
interface ahb_decode_mux_dp_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SLAVE_COUNT   = 4,
  parameter int ERR_CNT_WIDTH = 16
);

  // master request
  logic [ADDR_WIDTH-1:0]              HADDR;
  logic [1:0]                         HTRANS;
  logic                               HWRITE;
  logic [2:0]                         HSIZE;
  logic [2:0]                         HBURST;
  logic [3:0]                         HPROT;
  logic [DATA_WIDTH-1:0]              HWDATA;

  // response to master
  logic [DATA_WIDTH-1:0]              HRDATA;
  logic                               HREADY;
  logic [1:0]                         HRESP;

  // broadcast to slaves
  logic [ADDR_WIDTH-1:0]              HADDR_slaves;
  logic [1:0]                         HTRANS_slaves;
  logic                               HWRITE_slaves;
  logic [2:0]                         HSIZE_slaves;
  logic [2:0]                         HBURST_slaves;
  logic [3:0]                         HPROT_slaves;
  logic [DATA_WIDTH-1:0]              HWDATA_slaves;
  logic                               HREADY_slaves_in;
  logic [SLAVE_COUNT-1:0]             HSEL_slaves;

  // slave responses
  logic [SLAVE_COUNT*DATA_WIDTH-1:0]  HRDATA_slaves;
  logic [SLAVE_COUNT-1:0]             HREADY_slaves;
  logic [SLAVE_COUNT*2-1:0]           HRESP_slaves;

  // error log
  logic [ERR_CNT_WIDTH-1:0]           err_count;
  logic [ADDR_WIDTH-1:0]              err_addr;

  // interconnect view: it is the slave of the master and drives the slave array
  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA_slaves, HREADY_slaves, HRESP_slaves,
    output HRDATA, HREADY, HRESP,
    output HADDR_slaves, HTRANS_slaves, HWRITE_slaves, HSIZE_slaves, HBURST_slaves,
    output HPROT_slaves, HWDATA_slaves, HREADY_slaves_in, HSEL_slaves,
    output err_count, err_addr
  );

  // environment view: the bus master plus the slave array
  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA_slaves, HREADY_slaves, HRESP_slaves,
    input  HRDATA, HREADY, HRESP,
    input  HADDR_slaves, HTRANS_slaves, HWRITE_slaves, HSIZE_slaves, HBURST_slaves,
    input  HPROT_slaves, HWDATA_slaves, HREADY_slaves_in, HSEL_slaves,
    input  err_count, err_addr
  );

endinterface

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - two-cycle ERROR responder for unmapped transfers with error log
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hready,
  input  logic                     no_hit,
  input  logic [1:0]               htrans,
  input  logic [ADDR_WIDTH-1:0]    haddr,
  output logic                     ds_hready,
  output logic [1:0]               ds_hresp,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    err_addr
);

  ds_state_e state;
  logic      accept_err;

  assign accept_err = hready && no_hit && is_active(htrans);

  // FSM with registered response outputs plus the error log
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DS_IDLE;
      ds_hready <= 1'b1;
      ds_hresp  <= HRESP_OKAY;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      if (accept_err) begin
        err_addr <= haddr;
        if (err_count != '1) begin
          err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
      end
      case (state)
        DS_IDLE: begin
          if (accept_err) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= HRESP_ERROR;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          ds_hready <= 1'b1;
          ds_hresp  <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (accept_err) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= HRESP_ERROR;
          end else begin
            state     <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
          end
        end
        default: begin
          state     <= DS_IDLE;
          ds_hready <= 1'b1;
          ds_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_decode_mux_dp.sv
// rtl/ahb_decode_mux_dp.sv - single-master AHB decoder with registered data-phase mux and default slave
module ahb_decode_mux_dp
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SLAVE_COUNT   = 4,
  parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int ERR_CNT_WIDTH = 16
) (
  input logic                HCLK,
  input logic                HRESET,
  ahb_decode_mux_dp_if.slave bus
);

  logic [SLAVE_COUNT-1:0]   hsel;
  logic                     hit;
  logic [SLAVE_COUNT:0]     dsel;
  logic [DATA_WIDTH-1:0]    hrdata;
  logic                     hready;
  logic [1:0]               hresp;
  logic                     ds_hready;
  logic [1:0]               ds_hresp;
  logic [ERR_CNT_WIDTH-1:0] err_count;
  logic [ADDR_WIDTH-1:0]    err_addr;

  // Address decode; scanning upward with a found flag lets the lowest index win overlaps
  always_comb begin
    hsel = '0;
    hit  = 1'b0;
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      if (!hit && ((bus.HADDR & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                   SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hsel[i] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  // Data-phase owner: captured when an address phase completes, held across wait states
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel <= {1'b1, {SLAVE_COUNT{1'b0}}};
    end else if (hready) begin
      dsel <= {~hit, hsel};
    end
  end

  // Response mux driven only by the registered owner, so it never follows the new address
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    if (dsel[SLAVE_COUNT]) begin
      hready = ds_hready;
      hresp  = ds_hresp;
    end else begin
      for (int i = 0; i < SLAVE_COUNT; i++) begin
        if (dsel[i]) begin
          hrdata = bus.HRDATA_slaves[i*DATA_WIDTH +: DATA_WIDTH];
          hready = bus.HREADY_slaves[i];
          hresp  = bus.HRESP_slaves[2*i +: 2];
        end
      end
    end
  end

  ahb_default_slave #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_default_slave (
    .clk       (HCLK),
    .rst       (HRESET),
    .hready    (hready),
    .no_hit    (~hit),
    .htrans    (bus.HTRANS),
    .haddr     (bus.HADDR),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  assign bus.HRDATA           = hrdata;
  assign bus.HREADY           = hready;
  assign bus.HRESP            = hresp;
  assign bus.HREADY_slaves_in = hready;
  assign bus.HSEL_slaves      = hsel;
  assign bus.err_count        = err_count;
  assign bus.err_addr         = err_addr;

  assign bus.HADDR_slaves  = bus.HADDR;
  assign bus.HTRANS_slaves = bus.HTRANS;
  assign bus.HWRITE_slaves = bus.HWRITE;
  assign bus.HSIZE_slaves  = bus.HSIZE;
  assign bus.HBURST_slaves = bus.HBURST;
  assign bus.HPROT_slaves  = bus.HPROT;
  assign bus.HWDATA_slaves = bus.HWDATA;

endmodule

// File: tb/tb_ahb_decode_mux_dp.sv
// tb/tb_ahb_decode_mux_dp.sv - directed bench with a transfer-level reference model for ahb_decode_mux_dp
module tb_ahb_decode_mux_dp;

  // narrow counter so saturation is reachable in a short run
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [31:0] IDLE_ADDR = 32'hF000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ahb_decode_mux_dp_if #(.ERR_CNT_WIDTH(CW)) bus ();

  ahb_decode_mux_dp #(.ERR_CNT_WIDTH(CW)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  // model state: who owns the data phase and where an error response stands
  int          m_owner = -1;
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [31:0] m_addr  = '0;
  bit          m_valid = 1'b0;

  // slave k owns the 256 MB region k*0x1000_0000 for k < 4
  function automatic int decode(input logic [31:0] a);
    int r;
    r = int'(a / 32'h1000_0000);
    return (r < 4) ? r : -1;
  endfunction

  function automatic logic exp_hready();
    if (m_owner >= 0) return bus.HREADY_slaves[m_owner];
    return (m_phase == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [1:0] exp_hresp();
    if (m_owner >= 0) return bus.HRESP_slaves[2*m_owner +: 2];
    return (m_phase != 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_hrdata();
    if (m_owner >= 0) return bus.HRDATA_slaves[32*m_owner +: 32];
    return 32'h0;
  endfunction

  function automatic logic [3:0] exp_hsel();
    int d;
    d = decode(bus.HADDR);
    return (d < 0) ? 4'b0000 : 4'(1 << d);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model advances on every clock edge
  always @(posedge clk) begin
    int d;
    if (rst) begin
      m_owner = -1;
      m_phase = 0;
      m_cnt   = 0;
      m_addr  = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (exp_hready()) begin
        d = decode(bus.HADDR);
        m_owner = d;
        if (d < 0 && bus.HTRANS[1]) begin
          m_phase = 1;
          m_addr  = bus.HADDR;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
          m_phase = 0;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end
    end
  end

  // compare DUT against the model every cycle, mid-period
  always @(negedge clk) begin
    if (m_valid) begin
      chk("hready", bus.HREADY, exp_hready());
      chk("hresp", bus.HRESP, exp_hresp());
      chk("hrdata", bus.HRDATA, exp_hrdata());
      chk("hready_slaves_in", bus.HREADY_slaves_in, exp_hready());
      chk("hsel", bus.HSEL_slaves, exp_hsel());
      chk("bcast_addr_data", {bus.HADDR_slaves, bus.HWDATA_slaves}, {bus.HADDR, bus.HWDATA});
      chk("bcast_ctrl",
          {bus.HTRANS_slaves, bus.HWRITE_slaves, bus.HSIZE_slaves, bus.HBURST_slaves, bus.HPROT_slaves},
          {bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT});
      chk("err_count", bus.err_count, 64'(m_cnt));
      chk("err_addr", bus.err_addr, m_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.HADDR  = IDLE_ADDR;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
  endtask

  task automatic slaves_default();
    bus.HREADY_slaves = 4'b1111;
    bus.HRESP_slaves  = 8'h00;
    bus.HRDATA_slaves = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  endtask

  task automatic nonseq(input logic [31:0] a, input logic wr);
    bus.HADDR  = a;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    bus.HSIZE  = 3'b010;
    bus.HBURST = 3'b000;
    bus.HPROT  = 4'b0011;
    bus.HWDATA = 32'h0;
    slaves_default();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_hready", bus.HREADY, 1'b1);
    chk("rst_hresp", bus.HRESP, 2'b00);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_err_count", bus.err_count, 4'h0);

    // idle bus stays OKAY, zero data
    step();
    #1;
    chk("idle_hready", bus.HREADY, 1'b1);
    chk("idle_hrdata", bus.HRDATA, 32'h0);

    // read slave 2 with one wait state
    nonseq(32'h2000_0010, 1'b0);
    #1;
    chk("t2_hsel", bus.HSEL_slaves, 4'b0100);
    step();
    drive_idle();
    bus.HREADY_slaves[2] = 1'b0;
    #1;
    chk("t2_wait_hready", bus.HREADY, 1'b0);
    step();
    bus.HREADY_slaves[2] = 1'b1;
    bus.HRDATA_slaves[95:64] = 32'hDEAD_BEEF;
    #1;
    chk("t2_hready", bus.HREADY, 1'b1);
    chk("t2_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
    chk("t2_hresp", bus.HRESP, 2'b00);
    step();
    slaves_default();

    // slave 0 write stalls two cycles while slave 3's address waits
    nonseq(32'h0000_0100, 1'b1);
    step();
    nonseq(32'h3000_0200, 1'b0);
    bus.HWDATA = 32'hCAFE_0001;
    bus.HREADY_slaves[0] = 1'b0;
    bus.HRDATA_slaves[31:0] = 32'h1111_0000;
    #1;
    chk("t3_stall1_hready", bus.HREADY, 1'b0);
    chk("t3_held_hsel", bus.HSEL_slaves, 4'b1000);
    chk("t3_stall_hrdata", bus.HRDATA, 32'h1111_0000);
    step();
    #1;
    chk("t3_stall2_hready", bus.HREADY, 1'b0);
    step();
    bus.HREADY_slaves[0] = 1'b1;
    #1;
    chk("t3_s0_hready", bus.HREADY, 1'b1);
    step();
    drive_idle();
    bus.HRDATA_slaves[127:96] = 32'h3333_0000;
    #1;
    chk("t3_s3_hrdata", bus.HRDATA, 32'h3333_0000);
    chk("t3_s3_hready", bus.HREADY, 1'b1);
    step();
    slaves_default();

    // unmapped NONSEQ gets the two-cycle ERROR
    nonseq(32'h8000_0000, 1'b0);
    #1;
    chk("t4_hsel", bus.HSEL_slaves, 4'b0000);
    step();
    drive_idle();
    #1;
    chk("t4_err1_hready", bus.HREADY, 1'b0);
    chk("t4_err1_hresp", bus.HRESP, 2'b01);
    chk("t4_err_count", bus.err_count, 4'h1);
    chk("t4_err_addr", bus.err_addr, 32'h8000_0000);
    step();
    #1;
    chk("t4_err2_hready", bus.HREADY, 1'b1);
    chk("t4_err2_hresp", bus.HRESP, 2'b01);
    step();
    #1;
    chk("t4_done_hresp", bus.HRESP, 2'b00);
    bus.HADDR = 32'h8000_0000;
    step();
    #1;
    chk("t4_idle_hready", bus.HREADY, 1'b1);
    chk("t4_idle_hresp", bus.HRESP, 2'b00);
    chk("t4_idle_count", bus.err_count, 4'h1);
    bus.HTRANS = 2'b01;
    step();
    #1;
    chk("t4_busy_hresp", bus.HRESP, 2'b00);

    // unmapped transfer pipelined into the ERR2 cycle
    nonseq(32'h8000_0004, 1'b0);
    step();
    nonseq(32'h9000_0008, 1'b0);
    #1;
    chk("t5_err1_count", bus.err_count, 4'h2);
    step();
    #1;
    chk("t5_err2_hready", bus.HREADY, 1'b1);
    step();
    #1;
    chk("t5_reerr_hready", bus.HREADY, 1'b0);
    chk("t5_reerr_hresp", bus.HRESP, 2'b01);
    chk("t5_reerr_count", bus.err_count, 4'h3);
    chk("t5_reerr_addr", bus.err_addr, 32'h9000_0008);
    for (int i = 0; i < 30; i++) step();
    #1;
    chk("t5_sat_count", bus.err_count, 4'hF);
    step();
    drive_idle();
    step();
    step();
    #1;
    chk("t5_sat_hold", bus.err_count, 4'hF);

    // reset while the default slave is in ERR1
    nonseq(32'hA000_0000, 1'b0);
    step();
    drive_idle();
    rst = 1'b1;
    #1;
    chk("t6_in_err1", bus.HREADY, 1'b0);
    step();
    rst = 1'b0;
    bus.HREADY_slaves = 4'b0000;
    bus.HRESP_slaves  = 8'hFF;
    bus.HRDATA_slaves = {4{32'hFFFF_FFFF}};
    #1;
    chk("t6_hready", bus.HREADY, 1'b1);
    chk("t6_hresp", bus.HRESP, 2'b00);
    chk("t6_hrdata", bus.HRDATA, 32'h0);
    chk("t6_err_count", bus.err_count, 4'h0);
    chk("t6_err_addr", bus.err_addr, 32'h0);
    step();
    slaves_default();

    // slave responses pass through unchanged
    nonseq(32'h1000_0000, 1'b0);
    step();
    drive_idle();
    bus.HREADY_slaves[1] = 1'b0;
    bus.HRESP_slaves[3:2] = 2'b10;
    #1;
    chk("t7_retry_hresp", bus.HRESP, 2'b10);
    chk("t7_retry_hready", bus.HREADY, 1'b0);
    step();
    bus.HREADY_slaves[1] = 1'b1;
    bus.HRESP_slaves[3:2] = 2'b11;
    #1;
    chk("t7_split_hresp", bus.HRESP, 2'b11);
    step();
    slaves_default();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
